// File: rtl/data_ram_resp.sv
// Word-addressed 32-bit data RAM with fixed wait states, byte-lane writes and a one-cycle ack.
// Optional out-of-range detection on the upper address bits via `DATA_RAM_RESP_RANGE_ERR_EN.
module data_ram_resp #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [3:0]  sel,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        ack,
  output logic        stall_req,
  output logic        err,
  output logic [1:0]  dbg_state_o
);

  // Handshake: ce is sampled only in IDLE; the access is then owned by the block
  // until the single ack cycle in DONE, regardless of later ce/input activity.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q;
  logic [3:0]          sel_q;
  logic [ADDR_W-1:0]   idx_q;
  logic [31:0]         wdata_q;
  logic                oor_q;
  logic [31:0]         dout_q;
  logic [31:0]         mem_q [2**ADDR_W];

  logic                capture;
  logic                enter_done;
  logic                oor_in;
  logic                acc_we;
  logic [3:0]          acc_sel;
  logic [ADDR_W-1:0]   acc_idx;
  logic [31:0]         acc_data;
  logic                acc_oor;
  logic                do_write;
  logic                do_read;

`ifdef DATA_RAM_RESP_RANGE_ERR_EN
  assign oor_in = (addr[31:ADDR_W+2] != '0);
  logic unused_bits;
  assign unused_bits = ^addr[1:0];
`else
  assign oor_in = 1'b0;
  logic unused_bits;
  assign unused_bits = ^{addr[31:ADDR_W+2], addr[1:0], oor_q};
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    capture    = 1'b0;
    enter_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (ce) begin
          capture = 1'b1;
          cnt_d   = WAIT_LD;
          if (WAIT_LD == 4'd0) begin
            state_d    = DONE;
            enter_done = 1'b1;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          cnt_d      = 4'd0;
          state_d    = DONE;
          enter_done = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // With zero wait states the commit happens on the capture edge, so use live inputs then.
  always_comb begin
    if (state_q == IDLE) begin
      acc_we   = we;
      acc_sel  = sel;
      acc_idx  = addr[ADDR_W+1:2];
      acc_data = data_in;
      acc_oor  = oor_in;
    end else begin
      acc_we   = we_q;
      acc_sel  = sel_q;
      acc_idx  = idx_q;
      acc_data = wdata_q;
      acc_oor  = oor_q;
    end
  end

  assign do_write = rst & enter_done & acc_we & ~acc_oor;
  assign do_read  = enter_done & ~acc_we;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      dout_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (do_read) dout_q <= acc_oor ? 32'd0 : mem_q[acc_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      oor_q <= 1'b0;
    end else if (capture) begin
      oor_q <= oor_in;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      we_q    <= we;
      sel_q   <= sel;
      idx_q   <= addr[ADDR_W+1:2];
      wdata_q <= data_in;
    end
  end

  // Storage is intentionally left out of reset.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_sel[b]) mem_q[acc_idx][8*b +: 8] <= acc_data[8*b +: 8];
      end
    end
  end

  assign data_out    = dout_q;
  assign ack         = (state_q == DONE);
  assign stall_req   = rst & ((state_q == BUSY) | ((state_q == IDLE) & ce));
  assign dbg_state_o = state_q;

`ifdef DATA_RAM_RESP_RANGE_ERR_EN
  assign err = (state_q == DONE) & oor_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_data_ram_resp.sv
// Directed bench for data_ram_resp: vector table on a 2-wait-state instance,
// plus reset, abort and zero-wait back-to-back sequences on a second instance.
module tb_data_ram_resp;

  localparam int WAIT_A = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce, we;
  logic [31:0] addr, data_in;
  logic [3:0]  sel;
  logic [31:0] data_out;
  logic        ack, stall_req, err;
  logic [1:0]  dbg_state;

  logic        ce_b, we_b;
  logic [31:0] addr_b, din_b;
  logic [3:0]  sel_b;
  logic [31:0] dout_b;
  logic        ack_b, stall_b, err_b;
  logic [1:0]  dbg_b;

  int n_checks = 0;
  int n_err    = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] data;
    logic [31:0] exp_dout;
    logic        exp_err;
  } vec_t;

  vec_t vecs[15];

  always #5 clk = ~clk;

  data_ram_resp #(.ADDR_W(10), .WAIT_CYCLES(WAIT_A)) dut_a (
    .clk(clk), .rst(rst), .ce(ce), .we(we), .addr(addr), .sel(sel),
    .data_in(data_in), .data_out(data_out), .ack(ack), .stall_req(stall_req),
    .err(err), .dbg_state_o(dbg_state)
  );

  data_ram_resp #(.ADDR_W(10), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .ce(ce_b), .we(we_b), .addr(addr_b), .sel(sel_b),
    .data_in(din_b), .data_out(dout_b), .ack(ack_b), .stall_req(stall_b),
    .err(err_b), .dbg_state_o(dbg_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_access(input logic w, input logic [31:0] a, input logic [3:0] s,
                           input logic [31:0] d, input logic e_err);
    int n;
    bit got;
    logic [31:0] e_dout;
    @(negedge clk);
    ce = 1'b1; we = w; addr = a; sel = s; data_in = d;
    #1;
    check("stall_idle_ce", {31'd0, stall_req}, 32'd1);
    @(negedge clk);
    n = 1;
    // Scramble inputs after capture; the in-flight access must not notice.
    ce = 1'b0; we = ~w; addr = 32'h3FC; sel = 4'hF; data_in = 32'h0;
    got = 1'b0;
    while (!got && n < 40) begin
      if (ack) begin
        got = 1'b1;
      end else begin
        check("stall_busy", {31'd0, stall_req}, 32'd1);
        @(negedge clk);
        n++;
      end
    end
    e_dout = exp_q.pop_front();
    if (!got) begin
      n_checks++;
      n_err++;
      $display("FAIL ack_timeout: got no ack within %0d cycles, required one", n);
    end else begin
      check("latency", n, WAIT_A + 1);
      check("stall_done", {31'd0, stall_req}, 32'd0);
      check("dbg_done", {30'd0, dbg_state}, 32'd2);
      check("data_out", data_out, e_dout);
      check("err", {31'd0, err}, {31'd0, e_err});
      @(negedge clk);
      check("ack_one_cycle", {31'd0, ack}, 32'd0);
      check("data_out_hold", data_out, e_dout);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks;
    vecs[0]  = '{1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 32'h10, 4'hF, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h20, 4'hF, 32'h11223344, 32'hDEADBEEF, 1'b0};
    vecs[3]  = '{1'b1, 32'h20, 4'h5, 32'hAABBCCDD, 32'hDEADBEEF, 1'b0};
    vecs[4]  = '{1'b0, 32'h20, 4'h0, 32'h0,        32'h11BB33DD, 1'b0};
    vecs[5]  = '{1'b1, 32'h20, 4'h0, 32'hFFFFFFFF, 32'h11BB33DD, 1'b0};
    vecs[6]  = '{1'b0, 32'h20, 4'h3, 32'h0,        32'h11BB33DD, 1'b0};
    vecs[7]  = '{1'b1, 32'h24, 4'hF, 32'h01234567, 32'h11BB33DD, 1'b0};
    vecs[8]  = '{1'b1, 32'h24, 4'hA, 32'hCAFEF00D, 32'h11BB33DD, 1'b0};
    vecs[9]  = '{1'b0, 32'h24, 4'hF, 32'h0,        32'hCA23F067, 1'b0};
    vecs[10] = '{1'b1, 32'h0,  4'hF, 32'h55AA55AA, 32'hCA23F067, 1'b0};
    vecs[11] = '{1'b0, 32'h0,  4'hF, 32'h0,        32'h55AA55AA, 1'b0};
`ifdef DATA_RAM_RESP_RANGE_ERR_EN
    vecs[12] = '{1'b0, 32'h1000, 4'hF, 32'h0,        32'h0,        1'b1};
    vecs[13] = '{1'b1, 32'h1000, 4'hF, 32'h12345678, 32'h0,        1'b1};
    vecs[14] = '{1'b0, 32'h0,    4'hF, 32'h0,        32'h55AA55AA, 1'b0};
`else
    vecs[12] = '{1'b0, 32'h1000, 4'hF, 32'h0,        32'h55AA55AA, 1'b0};
    vecs[13] = '{1'b1, 32'h1000, 4'hF, 32'h12345678, 32'h55AA55AA, 1'b0};
    vecs[14] = '{1'b0, 32'h0,    4'hF, 32'h0,        32'h12345678, 1'b0};
`endif

    // Reset with ce asserted: stall must stay low.
    rst = 1'b0; ce = 1'b1; we = 1'b0; addr = 32'h0; sel = 4'hF; data_in = 32'h0;
    ce_b = 1'b1; we_b = 1'b0; addr_b = 32'h0; sel_b = 4'hF; din_b = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_stall", {31'd0, stall_req}, 32'd0);
    check("rst_stall_b", {31'd0, stall_b}, 32'd0);
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_data_out", data_out, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    ce = 1'b0; ce_b = 1'b0;
    rst = 1'b1;

    for (int i = 0; i < 15; i++) begin
      exp_q.push_back(vecs[i].exp_dout);
      do_access(vecs[i].we, vecs[i].addr, vecs[i].sel, vecs[i].data, vecs[i].exp_err);
    end

    // Reset one cycle into a write: no ack, no commit.
    @(negedge clk);
    ce = 1'b1; we = 1'b1; addr = 32'h10; sel = 4'hF; data_in = 32'h0BADF00D;
    @(negedge clk);
    ce = 1'b0; rst = 1'b0;
    acks = (ack === 1'b1) ? 1 : 0;
    @(negedge clk);
    rst = 1'b1;
    check("abort_state", {30'd0, dbg_state}, 32'd0);
    check("abort_data_out", data_out, 32'd0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (ack === 1'b1) acks++;
    end
    check("abort_no_ack", acks, 0);
    exp_q.push_back(32'hDEADBEEF);
    do_access(1'b0, 32'h10, 4'hF, 32'h0, 1'b0);

    // Zero wait states, ce held for three reads: ack in cycles 1, 3, 5.
    @(negedge clk);
    ce_b = 1'b1;
    #1;
    check("b2b_stall_c0", {31'd0, stall_b}, 32'd1);
    check("b2b_ack_c0", {31'd0, ack_b}, 32'd0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check($sformatf("b2b_ack_c%0d", k), {31'd0, ack_b}, {31'd0, (k % 2) == 1});
      check($sformatf("b2b_stall_c%0d", k), {31'd0, stall_b}, {31'd0, (k % 2) == 0});
    end
    ce_b = 1'b0;
    @(negedge clk);
    check("b2b_ack_c6", {31'd0, ack_b}, 32'd0);
    check("b2b_state_c6", {30'd0, dbg_b}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/data_ram_resp.md
DATA_RAM_RESP -- requirements
Module: data_ram_resp

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, word-index width (depth 2^ADDR_W 32-bit words).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, wait states per access (0..15).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port ce  input  1  access request from the CPU data port.
REQ-006 SHALL have port we  input  1  1=write, 0=read.
REQ-007 SHALL have port addr  input  32  byte address; word index = addr[ADDR_W+1:2].
REQ-008 SHALL have port sel  input  4  byte-lane enables; sel[3] maps to bits 31:24, sel[0] to bits 7:0.
REQ-009 SHALL have port data_in  input  32  write data.
REQ-010 SHALL have port data_out  output  32  read data, registered.
REQ-011 SHALL have port ack  output  1  one-cycle completion pulse.
REQ-012 SHALL have port stall_req  output  1  pipeline-stall request to the CPU while an access is pending.
REQ-013 SHALL have port err  output  1  out-of-range flag, valid with ack.

Function
REQ-014 SHALL implement an FSM with states IDLE, BUSY, and DONE.
REQ-015 In IDLE with ce=1, the block SHALL capture addr/we/sel/data_in, load wait counter with WAIT_CYCLES, and go to BUSY (or to DONE if WAIT_CYCLES=0).
REQ-016 In BUSY, the counter SHALL decrement each cycle; the block SHALL go to DONE on the edge where the counter reaches 0.
REQ-017 On entering DONE: a write SHALL update only the lanes with sel=1 at the captured word; a read SHALL load the full word into data_out, ignoring sel.
REQ-018 In DONE, ack=1 for exactly one cycle; the next state SHALL be IDLE.
REQ-019 stall_req SHALL equal (state==BUSY) | (state==IDLE & ce), combinationally; it SHALL be 0 in DONE.
REQ-020 Latency: ce first seen in cycle 0 -> ack high in cycle WAIT_CYCLES+1.
REQ-021 Back-to-back: ce held high through DONE SHALL start a new access in the following IDLE cycle; one idle-state cycle separates accesses.
REQ-022 ce deasserted during BUSY SHALL NOT abort; the captured access SHALL complete and ack SHALL pulse.
REQ-023 Input changes after capture SHALL NOT affect the in-flight access.
REQ-024 data_out SHALL hold its value across writes and idle cycles; it SHALL change only on read completion or reset.
REQ-025 sel=4'b0000 write SHALL complete with ack and modify no storage.

Reset
REQ-026 With rst=0 at a rising edge: state=IDLE, counter=0, data_out=0, ack=0, err=0.
REQ-027 stall_req SHALL be 0 while rst=0, regardless of ce.
REQ-028 Reset mid-access SHALL abort it: no write committed, no ack.
REQ-029 Storage contents SHALL NOT be reset.

Configuration
REQ-030 Macro DATA_RAM_RESP_RANGE_ERR_EN SHALL control out-of-range checking.
REQ-031 When defined: if addr[31:ADDR_W+2]!=0, the access SHALL write nothing, return data_out=0 on reads, and assert err with ack.
REQ-032 When undefined: upper address bits SHALL be ignored (addresses alias modulo depth), and err SHALL be tied 0.

Verification
REQ-033 Reset, write addr=0x10 data=0xDEADBEEF sel=4'hF, read 0x10 -> ack at cycle 3 each (WAIT_CYCLES=2), data_out=0xDEADBEEF.
REQ-034 Word 0x20=0x11223344, write sel=4'b0101 data=0xAABBCCDD, read -> 0x11BB33DD.
REQ-035 WAIT_CYCLES=0, ce held high for 3 reads -> ack in cycles 1,3,5; stall_req low only in DONE cycles.
REQ-036 ce pulsed 1 cycle for a write, then rst=0 in cycle 1 -> no ack; subsequent read of that word returns the old value.
REQ-037 Macro defined, ADDR_W=10: read addr=0x00001000 -> ack with err=1, data_out=0; macro undefined: same read returns word 0 contents, err=0.
